// File: rtl/spi_reg_ctrl.sv
// Command/register stage behind a byte-wide SPI slave. It decodes read/write
// frames into an 8-bit register bank and supplies the reply byte for the next frame.
module spi_reg_ctrl #(
  parameter int N_REGS  = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data_in,
  input  logic                  tx_send,
  input  logic [7:0]            status_in,
  output logic [7:0]            data_out,
  output logic [8*N_REGS-1:0]   reg_flat,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  err_flag,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_DATA  = 2'd1;
  localparam logic [1:0] S_WAIT_DUMMY = 2'd2;

  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(N_REGS - 1);
  localparam logic [15:0]       CNT_LAST    = 16'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] cmd_addr;
  logic [15:0]       cnt;
  logic [7:0]        regs [N_REGS];

  logic [6:0]        rx_addr;
  logic [ADDR_W-1:0] rx_idx;
  logic              addr_ok;
  logic              expired;
  logic [7:0]        rd_data;

  assign rx_addr = data_in[6:0];
  assign rx_idx  = rx_addr[ADDR_W-1:0];
  assign addr_ok = ({1'b0, rx_addr} < 8'(N_REGS));
  assign expired = (cnt == CNT_LAST);
  assign rd_data = (rx_idx == STATUS_ADDR) ? status_in : regs[rx_idx];

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (tx_send && addr_ok)
          state_nxt = data_in[7] ? S_WAIT_DATA : S_WAIT_DUMMY;
      end
      S_WAIT_DATA, S_WAIT_DUMMY: begin
        if (tx_send || expired)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      data_out  <= 8'h00;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      err_flag  <= 1'b0;
      cnt       <= '0;
      cmd_addr  <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != S_IDLE);
      wr_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (tx_send) begin
            if (addr_ok) begin
              err_flag <= 1'b0;
              cmd_addr <= rx_idx;
              data_out <= data_in[7] ? 8'h00 : rd_data;
            end else begin
              err_flag <= 1'b1;
              data_out <= 8'hEE;
            end
          end
        end
        S_WAIT_DATA, S_WAIT_DUMMY: begin
          // A frame arriving on the expiry cycle takes priority over the abort.
          if (tx_send) begin
            cnt      <= '0;
            data_out <= 8'h00;
            if (state == S_WAIT_DATA && cmd_addr != STATUS_ADDR) begin
              wr_strobe <= 1'b1;
              wr_addr   <= cmd_addr;
            end
          end else if (expired) begin
            err_flag <= 1'b1;
            data_out <= 8'h00;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // NOTE: the register bank is reset because its contents drive board logic directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++)
        regs[i] <= 8'h00;
    end else begin
      regs[N_REGS-1] <= status_in;
      for (int i = 0; i < N_REGS - 1; i++) begin
        if (state == S_WAIT_DATA && tx_send && cmd_addr == ADDR_W'(i))
          regs[i] <= data_in;
      end
    end
  end

  always_comb begin
    reg_flat = '0;
    for (int k = 0; k < N_REGS; k++)
      reg_flat[8*k +: 8] = regs[k];
  end

endmodule
